execution_stage: RTL and testbench

//  EX stage of the 8-bit pipelined MIPS-style core. Computes one ALU result per clock from A, B and

---
 rtl/execution_stage.sv | 170 +++++++++++++++++
 tb/tb_execution_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/execution_stage.sv
// execution_stage -- EX stage of the 8-bit pipelined MIPS-style core.
//
// Computes one ALU result per clock from A, B and the decoded immediate
// (data_in) under a 5-bit opcode, then registers the result, the
// {V,S,C,Z} flags and the memory/write-back controls into the EX/MEM
// pipeline boundary.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous, active-low reset (clears every output)
//   A, B             operands rs / rt
//   data_in          immediate / offset (shift amount in bits [2:0])
//   op_dec           opcode
//   mem_en_dec, mem_rw_dec, mem_mux_sel_dec, RW_dec   controls from decode
//   ans_ex, flag_ex  registered ALU result and flags {V,S,C,Z}
//   data_out         registered data_in
//   B_Bypass         registered B (store data)
//   mem_en_ex, mem_rw_ex, mem_mux_sel_ex, RW_ex       registered controls
//
// Flow control: there is no valid/ready handshake. Every rising edge
// accepts the current decode inputs and presents them one cycle later.
// There is no FSM; the only state is the EX/MEM register set itself.
module execution_stage (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [7:0] data_in,
  input  logic [4:0] op_dec,
  input  logic       mem_en_dec,
  input  logic       mem_rw_dec,
  input  logic       mem_mux_sel_dec,
  input  logic [4:0] RW_dec,
  output logic [7:0] ans_ex,
  output logic [3:0] flag_ex,
  output logic [7:0] data_out,
  output logic [7:0] B_Bypass,
  output logic       mem_en_ex,
  output logic       mem_rw_ex,
  output logic       mem_mux_sel_ex,
  output logic [4:0] RW_ex
);

  localparam logic [4:0] OP_ADD  = 5'b00000, OP_SUB  = 5'b00001, OP_MOV  = 5'b00010;
  localparam logic [4:0] OP_AND  = 5'b00100, OP_OR   = 5'b00101, OP_XOR  = 5'b00110;
  localparam logic [4:0] OP_NOT  = 5'b00111, OP_ADDI = 5'b01000, OP_SUBI = 5'b01001;
  localparam logic [4:0] OP_MOVI = 5'b01010, OP_ANDI = 5'b01100, OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_XORI = 5'b01110, OP_INC  = 5'b01111, OP_DEC  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001, OP_SLL  = 5'b10100, OP_SRL  = 5'b10101;
  localparam logic [4:0] OP_SRA  = 5'b10110, OP_ROL  = 5'b10111, OP_ROR  = 5'b11000;
  localparam logic [4:0] OP_LD   = 5'b11001, OP_ST   = 5'b11010, OP_CMP  = 5'b11011;
  localparam logic [4:0] OP_ADC  = 5'b11100, OP_SBB  = 5'b11101, OP_SWAP = 5'b11110;

  // Result class: selects which flag rules apply.
  localparam logic [1:0] K_LOGIC = 2'd0, K_ADD = 2'd1, K_SUB = 2'd2;

  logic [2:0] sh;
  logic [3:0] rot_back;
  logic [8:0] sll9, srl9;
  logic signed [8:0] sra9;
  logic [7:0] rol8, ror8;

  // Shifts carry one extra bit so the last bit shifted out lands in a
  // fixed position; with sh=0 that bit is naturally 0.
  assign sh       = data_in[2:0];
  assign rot_back = 4'd8 - {1'b0, sh};
  assign sll9     = {1'b0, A} << sh;
  assign srl9     = {A, 1'b0} >> sh;
  assign sra9     = $signed({A, 1'b0}) >>> sh;
  assign rol8     = (A << sh) | (A >> rot_back);
  assign ror8     = (A >> sh) | (A << rot_back);

  logic [1:0] kind;
  logic [7:0] x, y, lres, res, ans_n;
  logic       ci, lc, c, v, upd, keep_a;
  logic [8:0] sum9, dif9;
  logic [3:0] flag_n;

  always_comb begin
    kind   = K_LOGIC;
    x      = A;
    y      = B;
    ci     = 1'b0;
    lres   = 8'h00;
    lc     = 1'b0;
    upd    = 1'b1;
    keep_a = 1'b0;
    case (op_dec)
      OP_ADD:  kind = K_ADD;
      OP_SUB:  kind = K_SUB;
      OP_MOV:  lres = A;
      OP_AND:  lres = A & B;
      OP_OR:   lres = A | B;
      OP_XOR:  lres = A ^ B;
      OP_NOT:  lres = ~A;
      OP_ADDI: begin kind = K_ADD; y = data_in; end
      OP_SUBI: begin kind = K_SUB; y = data_in; end
      OP_MOVI: lres = data_in;
      OP_ANDI: lres = A & data_in;
      OP_ORI:  lres = A | data_in;
      OP_XORI: lres = A ^ data_in;
      OP_INC:  begin kind = K_ADD; y = 8'h01; end
      OP_DEC:  begin kind = K_SUB; y = 8'h01; end
      OP_NEG:  begin kind = K_SUB; x = 8'h00; y = A; end
      OP_SLL:  begin lres = sll9[7:0]; lc = sll9[8]; end
      OP_SRL:  begin lres = srl9[8:1]; lc = srl9[0]; end
      OP_SRA:  begin lres = sra9[8:1]; lc = sra9[0]; end
      // Rotates: the last bit rotated out reappears at the far end.
      OP_ROL:  begin lres = rol8; lc = (sh != 3'd0) & rol8[0]; end
      OP_ROR:  begin lres = ror8; lc = (sh != 3'd0) & ror8[7]; end
      OP_LD,
      OP_ST:   begin kind = K_ADD; y = data_in; end
      OP_CMP:  begin kind = K_SUB; keep_a = 1'b1; end
      OP_ADC:  begin kind = K_ADD; ci = flag_ex[1]; end
      OP_SBB:  begin kind = K_SUB; ci = flag_ex[1]; end
      OP_SWAP: lres = {A[3:0], A[7:4]};
      default: upd = 1'b0;  // NOP and reserved codes hold ans/flags
    endcase

    sum9 = {1'b0, x} + {1'b0, y} + {8'h00, ci};
    // Bit 8 of the 9-bit difference is the borrow (x < y + ci).
    dif9 = {1'b0, x} - {1'b0, y} - {8'h00, ci};

    case (kind)
      K_ADD: begin
        res = sum9[7:0];
        c   = sum9[8];
        v   = (x[7] == y[7]) && (res[7] != x[7]);
      end
      K_SUB: begin
        res = dif9[7:0];
        c   = dif9[8];
        v   = (x[7] != y[7]) && (res[7] != x[7]);
      end
      default: begin
        res = lres;
        c   = lc;
        v   = 1'b0;
      end
    endcase

    ans_n  = keep_a ? A : res;
    flag_n = {v, res[7], c, (res == 8'h00)};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ans_ex         <= 8'h00;
      flag_ex        <= 4'h0;
      data_out       <= 8'h00;
      B_Bypass       <= 8'h00;
      mem_en_ex      <= 1'b0;
      mem_rw_ex      <= 1'b0;
      mem_mux_sel_ex <= 1'b0;
      RW_ex          <= 5'd0;
    end else begin
      if (upd) begin
        ans_ex  <= ans_n;
        flag_ex <= flag_n;
      end
      data_out       <= data_in;
      B_Bypass       <= B;
      mem_en_ex      <= mem_en_dec;
      mem_rw_ex      <= mem_rw_dec;
      mem_mux_sel_ex <= mem_mux_sel_dec;
      RW_ex          <= RW_dec;
    end
  end

endmodule

// File: tb/tb_execution_stage.sv
// tb_execution_stage -- self-checking bench for execution_stage.
// Table of {inputs, expected ans/flags} records applied in order, a few
// hand-written reset sequences, and a short random ADD/SUB/XOR run checked
// against an integer reference model. Expected outputs are queued when a
// vector is driven and popped when the registered result appears.
module tb_execution_stage;

  logic       clk;
  logic       reset;
  logic [7:0] A, B, data_in;
  logic [4:0] op_dec;
  logic       mem_en_dec, mem_rw_dec, mem_mux_sel_dec;
  logic [4:0] RW_dec;
  logic [7:0] ans_ex;
  logic [3:0] flag_ex;
  logic [7:0] data_out, B_Bypass;
  logic       mem_en_ex, mem_rw_ex, mem_mux_sel_ex;
  logic [4:0] RW_ex;

  execution_stage dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .data_in(data_in), .op_dec(op_dec),
    .mem_en_dec(mem_en_dec), .mem_rw_dec(mem_rw_dec), .mem_mux_sel_dec(mem_mux_sel_dec),
    .RW_dec(RW_dec), .ans_ex(ans_ex), .flag_ex(flag_ex), .data_out(data_out),
    .B_Bypass(B_Bypass), .mem_en_ex(mem_en_ex), .mem_rw_ex(mem_rw_ex),
    .mem_mux_sel_ex(mem_mux_sel_ex), .RW_ex(RW_ex)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vectors ----------------
  typedef struct {
    logic [4:0] op;
    logic [7:0] a, b, i;
    logic [2:0] ctl;   // {mem_en, mem_rw, mem_mux_sel}
    logic [4:0] rw;
    logic [7:0] ans;
    logic [3:0] flg;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] i, input logic [2:0] ctl, input logic [4:0] rw,
                              input logic [7:0] ans, input logic [3:0] flg);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.i = i; v.ctl = ctl; v.rw = rw; v.ans = ans; v.flg = flg;
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  // {ans, flags, data_out, B_Bypass, en, rw, mux, RW}
  logic [35:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [35:0] actual_out();
    return {ans_ex, flag_ex, data_out, B_Bypass, mem_en_ex, mem_rw_ex, mem_mux_sel_ex, RW_ex};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input vec_t v);
    op_dec = v.op; A = v.a; B = v.b; data_in = v.i;
    {mem_en_dec, mem_rw_dec, mem_mux_sel_dec} = v.ctl;
    RW_dec = v.rw;
    exp_q.push_back({v.ans, v.flg, v.i, v.b, v.ctl, v.rw});
  endtask

  task automatic collect(input string tag);
    logic [35:0] e, a;
    a = actual_out();
    if (exp_q.size() == 0) begin
      check({tag, " queue"}, 36'h1, 36'h0);
    end else begin
      e = exp_q.pop_front();
      check({tag, " ans"},  {28'h0, a[35:28]}, {28'h0, e[35:28]});
      check({tag, " flag"}, {32'h0, a[27:24]}, {32'h0, e[27:24]});
      check({tag, " pass"}, {12'h0, a[23:0]},  {12'h0, e[23:0]});
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    collect(tag);
  endtask

  // Integer reference for ADD(0)/SUB(1)/XOR(2): returns {ans, flags}.
  function automatic logic [11:0] model(input int op, input int a, input int b);
    int r, s, sa, sb;
    logic c, v;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    c = 1'b0; v = 1'b0; r = 0;
    if (op == 0) begin
      r = a + b; c = (r > 255); s = sa + sb; v = (s > 127) || (s < -128);
    end else if (op == 1) begin
      r = a - b; c = (a < b); s = sa - sb; v = (s > 127) || (s < -128);
    end else begin
      r = a ^ b;
    end
    r = r & 255;
    return {r[7:0], v, r[7], c, (r == 0)};
  endfunction

  // ---------------- test ----------------
  initial begin
    vec_t v;
    logic [11:0] m;
    int op, a, b;

    // ADD SUB AND OR XOR NOT ADDI MOVI INC DEC NEG rsv SLL rsv SUBI NOP rsv rsv
    tbl.push_back(mk(5'b00000, 8'h40, 8'hC0, 8'h08, 3'b000, 5'h05, 8'h00, 4'b0011));
    tbl.push_back(mk(5'b00001, 8'h40, 8'hC0, 8'h08, 3'b000, 5'h05, 8'h80, 4'b1110));
    tbl.push_back(mk(5'b00100, 8'h40, 8'hC0, 8'h08, 3'b000, 5'h05, 8'h40, 4'b0000));
    tbl.push_back(mk(5'b00101, 8'h40, 8'hC0, 8'h08, 3'b000, 5'h05, 8'hC0, 4'b0100));
    tbl.push_back(mk(5'b00110, 8'h40, 8'hC0, 8'h08, 3'b000, 5'h05, 8'h80, 4'b0100));
    tbl.push_back(mk(5'b00111, 8'h40, 8'hC0, 8'h08, 3'b000, 5'h05, 8'hBF, 4'b0100));
    tbl.push_back(mk(5'b01000, 8'h40, 8'hC0, 8'h08, 3'b000, 5'h05, 8'h48, 4'b0000));
    tbl.push_back(mk(5'b01010, 8'h40, 8'hC0, 8'h08, 3'b000, 5'h05, 8'h08, 4'b0000));
    tbl.push_back(mk(5'b01111, 8'h40, 8'hC0, 8'h08, 3'b000, 5'h05, 8'h41, 4'b0000));
    tbl.push_back(mk(5'b10000, 8'h40, 8'hC0, 8'h08, 3'b000, 5'h05, 8'h3F, 4'b0000));
    tbl.push_back(mk(5'b10001, 8'h40, 8'hC0, 8'h08, 3'b000, 5'h05, 8'hC0, 4'b0110));
    tbl.push_back(mk(5'b01011, 8'h40, 8'hC0, 8'h08, 3'b000, 5'h05, 8'hC0, 4'b0110));
    tbl.push_back(mk(5'b10100, 8'h40, 8'hC0, 8'h08, 3'b000, 5'h05, 8'h40, 4'b0000));
    tbl.push_back(mk(5'b00011, 8'h40, 8'hC0, 8'h08, 3'b000, 5'h05, 8'h40, 4'b0000));
    tbl.push_back(mk(5'b01001, 8'h40, 8'hC0, 8'h08, 3'b000, 5'h05, 8'h38, 4'b0000));
    tbl.push_back(mk(5'b11111, 8'h40, 8'hC0, 8'h08, 3'b000, 5'h05, 8'h38, 4'b0000));
    tbl.push_back(mk(5'b10010, 8'h40, 8'hC0, 8'h08, 3'b000, 5'h05, 8'h38, 4'b0000));
    tbl.push_back(mk(5'b10011, 8'h40, 8'hC0, 8'h08, 3'b000, 5'h05, 8'h38, 4'b0000));
    // LD ST CMP SWAP MOV with all controls set
    tbl.push_back(mk(5'b11001, 8'hC0, 8'h01, 8'h08, 3'b111, 5'h0A, 8'hC8, 4'b0100));
    tbl.push_back(mk(5'b11010, 8'hC0, 8'h01, 8'h08, 3'b111, 5'h0A, 8'hC8, 4'b0100));
    tbl.push_back(mk(5'b11011, 8'hC0, 8'h01, 8'h08, 3'b111, 5'h0A, 8'hC0, 4'b0100));
    tbl.push_back(mk(5'b11110, 8'hC0, 8'h01, 8'h08, 3'b111, 5'h0A, 8'h0C, 4'b0000));
    tbl.push_back(mk(5'b00010, 8'hC0, 8'h01, 8'h08, 3'b111, 5'h0A, 8'hC0, 4'b0100));
    // ANDI ORI XORI
    tbl.push_back(mk(5'b01100, 8'hC0, 8'h01, 8'h0F, 3'b101, 5'h1F, 8'h00, 4'b0001));
    tbl.push_back(mk(5'b01101, 8'hC0, 8'h01, 8'h0F, 3'b101, 5'h1F, 8'hCF, 4'b0100));
    tbl.push_back(mk(5'b01110, 8'hC0, 8'h01, 8'h0F, 3'b101, 5'h1F, 8'hCF, 4'b0100));
    // carry chain: ADD, ADC(Cin=1), SUB, SBB(Cin=1), ADC(Cin=0), overflow cases
    tbl.push_back(mk(5'b00000, 8'hFF, 8'h01, 8'h00, 3'b010, 5'h11, 8'h00, 4'b0011));
    tbl.push_back(mk(5'b11100, 8'h00, 8'h00, 8'h00, 3'b010, 5'h11, 8'h01, 4'b0000));
    tbl.push_back(mk(5'b00001, 8'h00, 8'h01, 8'h00, 3'b010, 5'h11, 8'hFF, 4'b0110));
    tbl.push_back(mk(5'b11101, 8'h05, 8'h01, 8'h00, 3'b010, 5'h11, 8'h03, 4'b0000));
    tbl.push_back(mk(5'b11100, 8'h05, 8'h01, 8'h00, 3'b010, 5'h11, 8'h06, 4'b0000));
    tbl.push_back(mk(5'b00000, 8'h7F, 8'h01, 8'h00, 3'b010, 5'h11, 8'h80, 4'b1100));
    tbl.push_back(mk(5'b00001, 8'h80, 8'h01, 8'h00, 3'b010, 5'h11, 8'h7F, 4'b1000));
    // shifts / rotates
    tbl.push_back(mk(5'b10100, 8'h81, 8'h5A, 8'h01, 3'b001, 5'h03, 8'h02, 4'b0010));
    tbl.push_back(mk(5'b10101, 8'h81, 8'h5A, 8'h01, 3'b001, 5'h03, 8'h40, 4'b0010));
    tbl.push_back(mk(5'b10110, 8'h81, 8'h5A, 8'h01, 3'b001, 5'h03, 8'hC0, 4'b0110));
    tbl.push_back(mk(5'b10111, 8'h81, 8'h5A, 8'h01, 3'b001, 5'h03, 8'h03, 4'b0010));
    tbl.push_back(mk(5'b11000, 8'h81, 8'h5A, 8'h01, 3'b001, 5'h03, 8'hC0, 4'b0110));
    tbl.push_back(mk(5'b10100, 8'h81, 8'h5A, 8'h03, 3'b001, 5'h03, 8'h08, 4'b0000));
    tbl.push_back(mk(5'b10101, 8'h85, 8'h5A, 8'h03, 3'b001, 5'h03, 8'h10, 4'b0010));
    tbl.push_back(mk(5'b10110, 8'h85, 8'h5A, 8'h03, 3'b001, 5'h03, 8'hF0, 4'b0110));
    tbl.push_back(mk(5'b10111, 8'h85, 8'h5A, 8'h03, 3'b001, 5'h03, 8'h2C, 4'b0000));
    tbl.push_back(mk(5'b11000, 8'h85, 8'h5A, 8'h03, 3'b001, 5'h03, 8'hB0, 4'b0110));
    tbl.push_back(mk(5'b10100, 8'h81, 8'h5A, 8'hF8, 3'b001, 5'h03, 8'h81, 4'b0100));

    // Power-on reset: outputs at 0 before any release.
    reset = 1'b0;
    op_dec = 5'd0; A = 8'h00; B = 8'h00; data_in = 8'h00;
    mem_en_dec = 1'b0; mem_rw_dec = 1'b0; mem_mux_sel_dec = 1'b0; RW_dec = 5'd0;
    #2;
    check("por_outputs", actual_out(), 36'h0);
    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[k]) apply(tbl[k], $sformatf("vec%0d", k));

    // Mid-cycle reset with non-zero outputs: clears without a clock edge.
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", actual_out(), 36'h0);
    @(posedge clk);
    #1;
    check("reset_held", actual_out(), 36'h0);

    // Release and load on the very first edge; Cin is 0 again after reset.
    @(negedge clk);
    reset = 1'b1;
    drive(mk(5'b11100, 8'h12, 8'h34, 8'h9C, 3'b110, 5'h15, 8'h46, 4'b0000));
    @(posedge clk);
    #1;
    collect("first_edge");

    // Random ADD/SUB/XOR against the integer model.
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 2);
      a  = $urandom_range(0, 255);
      b  = $urandom_range(0, 255);
      m  = model(op, a, b);
      v  = mk((op == 0) ? 5'b00000 : (op == 1) ? 5'b00001 : 5'b00110,
              a[7:0], b[7:0], 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)),
              5'($urandom_range(0, 31)), m[11:4], m[3:0]);
      apply(v, $sformatf("rnd%0d", n));
    end

    check("queue_drained", {4'h0, 32'(exp_q.size())}, 36'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
